// File: rtl/sent_pkg.sv
// rtl/sent_pkg.sv - shared types, constants and CRC4 helper for the SENT transmitter
// Contents: FSM state enum, CRC4 seed/polynomial, nibble/pause length limits,
//           crc_t() returning (i << 4) mod poly for the nibble-wise CRC update.
package sent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_STATUS,
        ST_DATA,
        ST_CRC,
        ST_PAUSE
    } sent_state_e;

    localparam logic [3:0] CRC_SEED   = 4'b0101;
    localparam logic [4:0] CRC_POLY   = 5'h1D;   // x^4 + x^3 + x^2 + 1
    localparam logic [9:0] NIB_OFFSET = 10'd12;
    localparam logic [9:0] PAUSE_MAX  = 10'd768;
    localparam logic [9:0] PAUSE_MIN  = 10'd12;

    // Long division of {i, 4'b0000} by the CRC polynomial; result is the remainder.
    function automatic logic [3:0] crc_t(input logic [3:0] i);
        logic [7:0] r;
        r = {i, 4'b0000};
        for (int b = 7; b >= 4; b--) begin
            if (r[b]) begin
                r = r ^ ({3'b000, CRC_POLY} << (b - 4));
            end
        end
        return r[3:0];
    endfunction

endpackage

// File: rtl/sent_tick_gen.sv
// rtl/sent_tick_gen.sv - tick divider producing a one-clock strobe every div+1 clocks
// Ports: clk, reset (async, active-high), restart (clears the divider),
//        div (clocks per tick minus 1), tick (strobe at terminal count).
module sent_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || cnt == div) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == div) && !restart;

endmodule

// File: rtl/sent_tx_frame_gen.sv
// rtl/sent_tx_frame_gen.sv - SENT fast-channel frame transmitter with CRC4 and optional pause
// Ports: clk, reset (async, active-high); tick_div, data_in, status_in, crc_mode,
//        pause_en, data_valid / data_ready frame handshake; data_pulse (SENT line),
//        busy, frame_done (one clock on the last clock of a frame).
// Build option: SENT_PAUSE_EN adds the pause pulse that pads frames to FRAME_TICKS.
module sent_tx_frame_gen #(
    parameter int NIBBLES     = 6,
    parameter int DIV_W       = 16,
    parameter int LOW_TICKS   = 5,
    parameter int SYNC_TICKS  = 56,
    parameter int FRAME_TICKS = 282
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     tick_div,
    input  logic [4*NIBBLES-1:0] data_in,
    input  logic [3:0]           status_in,
    input  logic                 crc_mode,
    input  logic                 pause_en,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 data_pulse,
    output logic                 busy,
    output logic                 frame_done
);
    import sent_pkg::*;

    sent_state_e          state, state_next;
    logic [DIV_W-1:0]     div_q;
    logic [4*NIBBLES-1:0] data_sr;
    logic [3:0]           status_q, crc, crc_step;
    logic                 mode_q;
    logic [2:0]           nib_idx;
    logic [9:0]           tcnt, pulse_len, pause_len;
    logic                 tick, accept, pulse_end, last_nib, go_pause;

    assign data_ready = (state == ST_IDLE) && !reset;
    assign busy       = (state != ST_IDLE);
    assign accept     = data_valid && data_ready;
    assign last_nib   = (nib_idx == 3'(NIBBLES - 1));
    assign pulse_end  = tick && busy && (tcnt == pulse_len - 10'd1);

    sent_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (accept),
        .div     (div_q),
        .tick    (tick)
    );

`ifdef SENT_PAUSE_EN
    logic               pause_q;
    logic [11:0]        acc;
    logic signed [12:0] pause_rem;

    // acc holds the ticks of every completed pulse; in PAUSE that is the whole frame so far.
    always_comb begin
        pause_rem = $signed(13'(FRAME_TICKS)) - $signed({1'b0, acc});
        if (pause_rem < $signed({3'b000, PAUSE_MIN})) begin
            pause_len = PAUSE_MIN;
        end else if (pause_rem > $signed({3'b000, PAUSE_MAX})) begin
            pause_len = PAUSE_MAX;
        end else begin
            pause_len = pause_rem[9:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pause_q <= 1'b0;
            acc     <= '0;
        end else if (accept) begin
            pause_q <= pause_en;
            acc     <= '0;
        end else if (pulse_end) begin
            acc <= acc + 12'(pulse_len);
        end
    end

    assign go_pause = pause_q;
`else
    logic unused_pause_en;
    localparam int unused_frame_ticks = FRAME_TICKS;
    assign unused_pause_en = pause_en;
    assign go_pause        = 1'b0;
    assign pause_len       = PAUSE_MIN;
`endif

    always_comb begin
        pulse_len = 10'(SYNC_TICKS);
        case (state)
            ST_STATUS: pulse_len = NIB_OFFSET + {6'd0, status_q};
            ST_DATA:   pulse_len = NIB_OFFSET + {6'd0, data_sr[4*NIBBLES-1 -: 4]};
            ST_CRC:    pulse_len = NIB_OFFSET + {6'd0, crc};
            ST_PAUSE:  pulse_len = pause_len;
            default:   pulse_len = 10'(SYNC_TICKS);
        endcase
    end

    // Recommended mode folds the zero-nibble augment into the last data update so the
    // CRC value is final on the same edge that enters the CRC pulse.
    always_comb begin
        crc_step = crc_t(crc) ^ data_sr[4*NIBBLES-1 -: 4];
        if (last_nib && mode_q) begin
            crc_step = crc_t(crc_step);
        end
    end

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_SYNC;
            ST_SYNC:   if (pulse_end) state_next = ST_STATUS;
            ST_STATUS: if (pulse_end) state_next = ST_DATA;
            ST_DATA:   if (pulse_end && last_nib) state_next = ST_CRC;
            ST_CRC: begin
                if (pulse_end) begin
                    if (go_pause) begin
                        state_next = ST_PAUSE;
                    end else begin
                        state_next = ST_IDLE;
                        frame_done = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (pulse_end) begin
                    state_next = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            div_q      <= '0;
            data_sr    <= '0;
            status_q   <= '0;
            mode_q     <= 1'b0;
            crc        <= '0;
            nib_idx    <= '0;
            tcnt       <= '0;
            data_pulse <= 1'b1;
        end else begin
            state <= state_next;
            if (accept) begin
                div_q    <= tick_div;
                data_sr  <= data_in;
                status_q <= status_in;
                mode_q   <= crc_mode;
                crc      <= CRC_SEED;
                nib_idx  <= '0;
                tcnt     <= '0;
            end else if (tick && busy) begin
                if (pulse_end) begin
                    tcnt <= '0;
                    if (state == ST_DATA) begin
                        data_sr <= data_sr << 4;
                        nib_idx <= nib_idx + 3'd1;
                        crc     <= crc_step;
                    end
                end else begin
                    tcnt <= tcnt + 10'd1;
                end
            end
            // Registered so the line is glitch-free; it trails the state by one clock.
            data_pulse <= !(busy && tcnt < 10'(LOW_TICKS));
        end
    end

endmodule

// File: tb/tb_sent_tx_frame_gen.sv
// tb/tb_sent_tx_frame_gen.sv - directed self-checking bench for sent_tx_frame_gen
module tb_sent_tx_frame_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tick_div;
    logic [23:0] data_in;
    logic [3:0]  status_in;
    logic        crc_mode, pause_en, data_valid;
    logic        data_ready, data_pulse, busy, frame_done;

    int checks = 0;
    int errors = 0;
    int fall_c [16];
    int low_len[16];
    int nfalls, done_c, done_cnt, busy_len;

    sent_tx_frame_gen dut (
        .clk        (clk),
        .reset      (reset),
        .tick_div   (tick_div),
        .data_in    (data_in),
        .status_in  (status_in),
        .crc_mode   (crc_mode),
        .pause_en   (pause_en),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_pulse (data_pulse),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one frame; returns at the negedge right after the accept edge (cycle 0).
    task automatic send(input logic [15:0] d, input logic [23:0] data, input logic [3:0] st,
                        input logic mode, input logic pe);
        @(negedge clk);
        tick_div   = d;
        data_in    = data;
        status_in  = st;
        crc_mode   = mode;
        pause_en   = pe;
        data_valid = 1'b1;
        check("ready_before_accept", data_ready, 1);
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    // Records falling-edge cycles, low run lengths, frame_done and busy counts.
    task automatic capture(input int budget, input int poke_c);
        logic prev;
        prev     = 1'b1;
        nfalls   = 0;
        done_c   = -1;
        done_cnt = 0;
        busy_len = 0;
        for (int i = 0; i < 16; i++) begin
            fall_c[i]  = 0;
            low_len[i] = 0;
        end
        for (int c = 0; c < budget; c++) begin
            if (c == poke_c) begin
                data_in    = 24'hFFFFFF;
                crc_mode   = 1'b1;
                data_valid = 1'b1;
            end else if (c == poke_c + 1) begin
                data_valid = 1'b0;
            end
            if (prev && !data_pulse && nfalls < 16) begin
                fall_c[nfalls] = c;
                nfalls++;
            end
            if (!data_pulse && nfalls > 0) low_len[nfalls-1]++;
            if (frame_done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
            end
            if (busy) busy_len++;
            prev = data_pulse;
            if (done_c >= 0 && c >= done_c + 20) break;
            @(negedge clk);
        end
        check("frame_done_seen", done_c >= 0, 1);
    endtask

    // Pulse length in clocks; the line trails the state by one clock, hence the +2 on the last.
    function automatic int plen(input int i);
        if (i < nfalls - 1) return fall_c[i+1] - fall_c[i];
        return done_c + 2 - fall_c[i];
    endfunction

    initial begin
        reset      = 1'b1;
        tick_div   = '0;
        data_in    = '0;
        status_in  = '0;
        crc_mode   = 1'b0;
        pause_en   = 1'b0;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pulse", data_pulse, 1);
        check("rst_ready", data_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        reset = 1'b0;
        #1;
        check("idle_ready", data_ready, 1);

        // Legacy CRC, tick_div=2: CRC 0xD (25 ticks), frame 186 ticks.
        send(16'd2, 24'h123456, 4'h0, 1'b0, 1'b0);
        capture(3000, -1);
        check("a_nfalls", nfalls, 9);
        check("a_sync_len", plen(0), 168);
        check("a_sync_low", low_len[0], 15);
        check("a_status_len", plen(1), 36);
        check("a_data1_len", plen(2), 39);
        check("a_data6_len", plen(7), 54);
        check("a_crc_len", plen(8), 75);
        check("a_done_cnt", done_cnt, 1);
        check("a_busy_len", busy_len, 558);

        // Recommended CRC: 0x2 (14 ticks), frame 175 ticks.
        send(16'd2, 24'h123456, 4'h0, 1'b1, 1'b0);
        capture(3000, -1);
        check("b_crc_len", plen(8), 42);
        check("b_busy_len", busy_len, 525);
        check("b_done_cnt", done_cnt, 1);

        // tick_div=0, all-F data: 27-clock data pulses, legacy CRC 0x3.
        send(16'd0, 24'hFFFFFF, 4'h0, 1'b0, 1'b0);
        capture(1000, -1);
        for (int i = 2; i < 8; i++) check($sformatf("c_data%0d_len", i - 1), plen(i), 27);
        check("c_crc_len", plen(8), 15);

        // Reset during the sync low phase aborts the frame at once.
        send(16'd2, 24'h123456, 4'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("d_sync_low", data_pulse, 0);
        reset = 1'b1;
        #1;
        check("d_rst_pulse", data_pulse, 1);
        check("d_rst_busy", busy, 0);
        check("d_rst_ready", data_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("d_ready_after", data_ready, 1);
        check("d_busy_after", busy, 0);

        // Clean frame after the abort: tick_div=1, recommended mode.
        send(16'd1, 24'h123456, 4'h0, 1'b1, 1'b0);
        capture(2000, -1);
        check("e_nfalls", nfalls, 9);
        check("e_sync_len", plen(0), 112);
        check("e_crc_len", plen(8), 28);
        check("e_busy_len", busy_len, 350);

        // data_valid during busy with different data must be ignored.
        send(16'd0, 24'h000000, 4'hA, 1'b0, 1'b0);
        capture(1000, 40);
        check("f_nfalls", nfalls, 9);
        check("f_status_len", plen(1), 22);
        check("f_crc_len", plen(8), 27);
        check("f_busy_len", busy_len, 177);
        check("f_done_cnt", done_cnt, 1);

        // pause_en=1: pause of 107 ticks pads the frame to 282 ticks when built with the option.
        send(16'd2, 24'h123456, 4'h0, 1'b1, 1'b1);
        capture(3000, -1);
`ifdef SENT_PAUSE_EN
        check("g_nfalls", nfalls, 10);
        check("g_crc_len", plen(8), 42);
        check("g_pause_len", plen(9), 321);
        check("g_busy_len", busy_len, 846);
`else
        check("g_nfalls", nfalls, 9);
        check("g_busy_len", busy_len, 525);
`endif
        check("g_done_cnt", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
